rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one WIDTH-bit output channel between N requesters.
- Computes the grant, drives the select of an internal N:1 mux, and registers the selected beat into a one-entry output stage.
- Uses valid/ready handshakes on both sides.
- Sits in front of any shared sink that previously took a fixed mux select.

Parameters:
- WIDTH, 3: data width per requester.
- N, 4: number of requesters; legal range 2..16.
- SEL_W, $clog2(N): select width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N  per-requester beat valid
- req_last  in  N  per-requester end-of-packet flag, qualified by req_valid
- req_data  in  N*WIDTH  packed data; requester i at [i*WIDTH +: WIDTH]
- in_ready  out  N  per-requester accept; at most one bit set
- out_valid  out  1  output register holds a beat
- out_ready  in  1  sink accepts beat
- out_data  out  WIDTH  registered beat
- out_last  out  1  registered last flag
- out_select  out  SEL_W  index of the requester whose beat is in out_data

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, lock_idx=0, out_valid=0, out_data=0, out_last=0, out_select=0. in_ready=0 while reset is high.
- can_accept = !out_valid | out_ready. The output stage is a single register with full throughput: one beat per cycle when the sink is always ready.
- Grant, IDLE state:
  - Pick the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N.
  - If none is valid, there is no grant.
  - in_ready may depend combinationally on req_valid in IDLE.
- Grant, LOCKED state: the grant is lock_idx regardless of req_valid. Other requesters are starved until the packet ends.
- in_ready[g] = can_accept & (a grant exists); all other bits are 0.
- Transfer occurs when req_valid[g] & in_ready[g]. On the next edge:
  - out_data <= req_data[g]
  - out_last <= req_last[g]
  - out_select <= g
  - out_valid <= 1
- Latency from input handshake to out_valid is 1 cycle.
- No transfer, but out_ready=1 and out_valid=1: out_valid <= 0. out_data, out_last and out_select hold their last values.
- State transitions on a transfer:
  - req_last=0: go to LOCKED, lock_idx <= g.
  - req_last=1: go to IDLE, ptr <= (g+1) mod N, wrapping from N-1 to 0.
  - Single-beat packets never enter LOCKED.
- LOCKED with req_valid[lock_idx]=0: stay LOCKED, no transfer. Bubbles inside a packet are allowed.
- ptr changes only on a last-beat transfer. Idle cycles do not rotate priority.
- Simultaneous out_ready=1 and a new transfer: the old beat leaves and the new beat loads in the same edge, so out_valid stays 1.
- out_ready=0 with out_valid=1: in_ready is all zero, and out_data, out_last and out_select are stable.
- Reset mid-packet: LOCKED is abandoned, the output beat is dropped, and all registers return to their reset values. There is no recovery of a partial packet.
- A requester must hold req_data and req_last stable while req_valid=1 and not accepted. The bench checks this; the RTL does not.

Test Plan:
1. All four valid, single-beat (last=1), data i+1, out_ready=1, 8 cycles: out_select sequence is 0,1,2,3,0,1,2,3 and out_data is 1,2,3,4,...; in_ready is always one-hot.
2. Req1 sends a 3-beat packet (last=0,0,1) while req0 and req2 are continuously valid: after req0's beat, three consecutive beats come from select=1 with no interleave; the next grant is 2.
3. Req1 locked, req_valid[1] dropped for 2 cycles mid-packet while req3 is valid: no transfer and in_ready=4'b0010 while the output is empty; the packet resumes afterwards.
4. out_ready held 0 for 3 cycles with out_valid=1, data=3'b011: out_data, out_last and out_select are stable and in_ready=0; when out_ready returns to 1, a new beat loads on the same edge the held beat leaves.
5. reset asserted asynchronously mid-packet (between edges): out_valid=0 immediately; after release, the first grant scans from requester 0.
6. Only req3 valid, repeated single beats: back-to-back one beat per cycle, out_select=3 each time; ptr wraps 3->0 and req0's later request wins over req3.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Packet-aware round-robin arbiter: N requesters share one WIDTH-bit channel
// through a registered single-entry output stage with valid/ready on both sides.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req_valid,
  input  logic [N-1:0]       req_last,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_select
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] lock_q, lock_d;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr_inc;
  logic [SEL_W:0]   cand;
  logic             grant_found;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] data_arr [N];

  // Unpack the flat data bus into per-requester lanes for the mux.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant: locked requester owns the channel, otherwise scan from ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == LOCKED) begin
      grant_found = 1'b1;
      grant_idx   = lock_q;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(N)) begin
          cand = cand - (SEL_W+1)'(N);
        end
        if (!grant_found && req_valid[cand[SEL_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[SEL_W-1:0];
        end
      end
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign xfer       = !reset && grant_found && can_accept && req_valid[grant_idx];
  assign ptr_inc    = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);

  always_comb begin
    in_ready = '0;
    if (!reset && grant_found && can_accept) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next state: a non-last beat locks the channel, a last beat rotates priority.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (xfer) begin
      if (req_last[grant_idx]) begin
        state_d = IDLE;
        ptr_d   = ptr_inc;
      end else begin
        state_d = LOCKED;
        lock_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Output stage: load on transfer, drain when the sink takes the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_select <= '0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= data_arr[grant_idx];
      out_last   <= req_last[grant_idx];
      out_select <= grant_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with a reference arbitration model and beat scoreboard.
module tb_rr_mux_arbiter;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned N     = 4;
  localparam int unsigned SEL_W = 2;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_last;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SEL_W-1:0]   out_select;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit               m_locked;
  int               m_ptr;
  int               m_lock;
  bit               m_ov;
  logic [WIDTH-1:0] m_data;
  bit               m_last;
  logic [SEL_W-1:0] m_sel;
  beat_t            sb[$];

  rr_mux_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_select (out_select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_ptr    = 0;
    m_lock   = 0;
    m_ov     = 1'b0;
    m_data   = '0;
    m_last   = 1'b0;
    m_sel    = '0;
    sb.delete();
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input logic [WIDTH-1:0] d);
    req_valid[i]             = v;
    req_last[i]              = l;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  // One cycle: check in_ready against the model, push predicted beat, clock, pop and compare.
  task automatic step();
    bit           found;
    int           g;
    bit           can;
    bit           xfer;
    logic [N-1:0] exp_ir;
    beat_t        b;
    beat_t        got;
    #1;
    found = 1'b0;
    g     = 0;
    if (m_locked) begin
      found = 1'b1;
      g     = m_lock;
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (!found && req_valid[(m_ptr + k) % int'(N)]) begin
          found = 1'b1;
          g     = (m_ptr + k) % int'(N);
        end
      end
    end
    can    = !m_ov || out_ready;
    exp_ir = (found && can) ? N'(1 << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    xfer = found && can && req_valid[g];
    if (xfer) begin
      b.sel  = SEL_W'(g);
      b.data = req_data[g*WIDTH +: WIDTH];
      b.last = req_last[g];
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    if (xfer) begin
      got    = sb.pop_front();
      m_ov   = 1'b1;
      m_data = got.data;
      m_last = got.last;
      m_sel  = got.sel;
      if (got.last) begin
        m_locked = 1'b0;
        m_ptr    = (int'(got.sel) + 1) % int'(N);
      end else begin
        m_locked = 1'b1;
        m_lock   = int'(got.sel);
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    chk("out_valid",  32'(out_valid),  32'(m_ov));
    chk("out_data",   32'(out_data),   32'(m_data));
    chk("out_last",   32'(out_last),   32'(m_last));
    chk("out_select", 32'(out_select), 32'(m_sel));
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    clear_reqs();
    for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 1'b1, WIDTH'(i + 1));
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),   32'(0));
    chk("rst_out_valid", 32'(out_valid),  32'(0));
    chk("rst_out_data",  32'(out_data),   32'(0));
    chk("rst_out_sel",   32'(out_select), 32'(0));
    reset = 1'b0;

    // 1: all valid single beats rotate 0,1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_sel",  32'(out_select), 32'(k % 4));
      chk("t1_data", 32'(out_data),   32'(k % 4 + 1));
    end

    // 2: 3-beat packet from req1 is not interleaved
    clear_reqs();
    set_req(0, 1'b1, 1'b1, 3'd5);
    set_req(1, 1'b1, 1'b0, 3'd1);
    set_req(2, 1'b1, 1'b1, 3'd6);
    step(); chk("t2_sel_a", 32'(out_select), 32'(0));
    step(); chk("t2_sel_b", 32'(out_select), 32'(1));
    set_req(1, 1'b1, 1'b0, 3'd2);
    step(); chk("t2_sel_c", 32'(out_select), 32'(1));
    set_req(1, 1'b1, 1'b1, 3'd3);
    step(); chk("t2_sel_d", 32'(out_select), 32'(1));
    chk("t2_last", 32'(out_last), 32'(1));
    set_req(1, 1'b0, 1'b0, 3'd0);
    step(); chk("t2_next", 32'(out_select), 32'(2));

    // 3: bubble inside a locked packet starves req3
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 3'd4);
    step(); chk("t3_lock", 32'(out_select), 32'(1));
    set_req(1, 1'b0, 1'b0, 3'd4);
    set_req(3, 1'b1, 1'b1, 3'd7);
    step();
    step();
    chk("t3_bubble_ir", 32'(in_ready),  32'(4'b0010));
    chk("t3_bubble_ov", 32'(out_valid), 32'(0));
    set_req(1, 1'b1, 1'b1, 3'd5);
    step(); chk("t3_resume", 32'(out_data), 32'(5));
    set_req(1, 1'b0, 1'b0, 3'd0);
    step(); chk("t3_then3", 32'(out_select), 32'(3));

    // 4: backpressure holds the beat, then swap on the same edge
    clear_reqs();
    set_req(0, 1'b1, 1'b1, 3'b011);
    step(); chk("t4_load", 32'(out_data), 32'(3));
    out_ready = 1'b0;
    set_req(0, 1'b0, 1'b0, 3'd0);
    set_req(2, 1'b1, 1'b1, 3'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_hold_ir",   32'(in_ready), 32'(0));
      chk("t4_hold_data", 32'(out_data), 32'(3));
    end
    out_ready = 1'b1;
    step();
    chk("t4_swap_ov",   32'(out_valid),  32'(1));
    chk("t4_swap_data", 32'(out_data),   32'(5));
    chk("t4_swap_sel",  32'(out_select), 32'(2));

    // 5: async reset mid-packet
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 3'd6);
    step(); chk("t5_lock", 32'(out_select), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_ov", 32'(out_valid), 32'(0));
    chk("t5_rst_ir", 32'(in_ready),  32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 1'b1, WIDTH'(i + 1));
    step(); chk("t5_first", 32'(out_select), 32'(0));

    // 6: lone req3 streams back to back, then ptr wrap favours req0
    clear_reqs();
    set_req(3, 1'b1, 1'b1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_sel", 32'(out_select), 32'(3));
      chk("t6_ov",  32'(out_valid),  32'(1));
    end
    set_req(0, 1'b1, 1'b1, 3'd1);
    step(); chk("t6_wrap", 32'(out_select), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
